write_dispatcher: RTL

- Descriptor-driven sequencer for the Avalon-MM write master.
- Accepts transfer descriptors (base, length, fixed-location flag) from user/CPU logic and queues them in a DESC_DEPTH-entry FIFO.
- Issues each descriptor to the write master's control port (control_go pulse), waits for control_done, then retires it.
- Provides queue backpressure, an abort that flushes pending work, rejection of malformed descriptors, and completion/error counters.

---
 rtl/write_dispatcher.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/write_dispatcher.sv
// Descriptor-driven sequencer for an Avalon-MM write master: queues descriptors,
// issues them one at a time through the control port and retires them on control_done.
module write_dispatcher #(
    parameter int AVALON_ADDRESS_WIDTH     = 32,
    parameter int AVALON_BYTE_ENABLE_WIDTH = 4,
    parameter int DESC_DEPTH               = 4,
    parameter int DESC_DEPTH_LOG2          = 2,
    parameter int COUNT_WIDTH              = 16
) (
    input  logic                            M_AVALON_CLK,
    input  logic                            M_AVALON_RSTN,
    input  logic                            desc_valid,
    output logic                            desc_ready,
    input  logic [AVALON_ADDRESS_WIDTH-1:0] desc_base,
    input  logic [AVALON_ADDRESS_WIDTH-1:0] desc_length,
    input  logic                            desc_fixed,
    input  logic                            abort,
    output logic                            control_go,
    output logic [AVALON_ADDRESS_WIDTH-1:0] control_write_base,
    output logic [AVALON_ADDRESS_WIDTH-1:0] control_write_length,
    output logic                            control_fixed_location,
    input  logic                            control_done,
    output logic                            xfer_done,
    output logic                            desc_rejected,
    output logic                            busy,
    output logic [COUNT_WIDTH-1:0]          completed_count,
    output logic [COUNT_WIDTH-1:0]          error_count
);

    localparam int AW      = AVALON_ADDRESS_WIDTH;
    localparam int PW      = DESC_DEPTH_LOG2;
    localparam int BE_LOG2 = $clog2(AVALON_BYTE_ENABLE_WIDTH);
    localparam int EW      = 2 * AW + 1;

    localparam logic [PW-1:0]          PTR_ONE  = PW'(1);
    localparam logic [PW:0]            CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]            CNT_FULL = (PW + 1)'(DESC_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] STAT_ONE = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETIRE = 2'd3
    } state_t;

    function automatic logic len_bad(input logic [AW-1:0] len);
        return (len == '0) || (len[BE_LOG2-1:0] != '0);
    endfunction

    state_t                 state_q;
    logic [EW-1:0]          mem_q [DESC_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [PW:0]            count_q, count_d;
    logic                   full_q, empty_q;
    logic                   control_go_q, xfer_done_q, desc_rejected_q, fixed_q;
    logic [AW-1:0]          base_q, length_q;
    logic [COUNT_WIDTH-1:0] completed_q, error_q;

    logic          accept_s, bad_s, push_s, pop_s;
    logic [EW-1:0] head_s;

    assign accept_s = desc_valid & desc_ready;
    assign bad_s    = len_bad(desc_length);
    assign push_s   = accept_s & ~bad_s;
    // The FSM may only take a new descriptor when it has nothing in flight.
    assign pop_s    = ~empty_q & ((state_q == ST_IDLE) | (state_q == ST_RETIRE));
    assign head_s   = mem_q[rd_ptr_q];

    // Occupancy update for a push, a pop, or both.
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Descriptor storage; abort deasserts desc_ready so no push coincides with a flush.
    always_ff @(posedge M_AVALON_CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {desc_fixed, desc_length, desc_base};
        end
    end

    // Queue pointers and registered full/empty flags.
    always_ff @(posedge M_AVALON_CLK or negedge M_AVALON_RSTN) begin
        if (!M_AVALON_RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

    // Dispatch FSM; go and xfer_done are raised on entry to ISSUE and RETIRE.
    always_ff @(posedge M_AVALON_CLK or negedge M_AVALON_RSTN) begin
        if (!M_AVALON_RSTN) begin
            state_q      <= ST_IDLE;
            control_go_q <= 1'b0;
            xfer_done_q  <= 1'b0;
            base_q       <= '0;
            length_q     <= '0;
            fixed_q      <= 1'b0;
            completed_q  <= '0;
        end else begin
            control_go_q <= 1'b0;
            xfer_done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        {fixed_q, length_q, base_q} <= head_s;
                        control_go_q <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (control_done) begin
                        xfer_done_q <= 1'b1;
                        state_q     <= ST_RETIRE;
                    end
                end
                ST_RETIRE: begin
                    completed_q <= completed_q + STAT_ONE;
                    if (pop_s) begin
                        {fixed_q, length_q, base_q} <= head_s;
                        control_go_q <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Rejection pulse and error counter for malformed descriptors.
    always_ff @(posedge M_AVALON_CLK or negedge M_AVALON_RSTN) begin
        if (!M_AVALON_RSTN) begin
            desc_rejected_q <= 1'b0;
            error_q         <= '0;
        end else begin
            desc_rejected_q <= accept_s & bad_s;
            if (accept_s && bad_s) error_q <= error_q + STAT_ONE;
        end
    end

    assign desc_ready             = ~full_q & ~abort;
    assign busy                   = ~empty_q | (state_q != ST_IDLE);
    assign control_go             = control_go_q;
    assign control_write_base     = base_q;
    assign control_write_length   = length_q;
    assign control_fixed_location = fixed_q;
    assign xfer_done              = xfer_done_q;
    assign desc_rejected          = desc_rejected_q;
    assign completed_count        = completed_q;
    assign error_count            = error_q;

endmodule
